ripple_adder16: RTL and testbench
=================================

Name: ripple_adder16

Overview:
- 16-bit unsigned binary adder: two 16-bit operands in, 16-bit sum and carry-out.
- Built as a ripple chain of 1-bit full adders, grouped into four 4-bit slices.
- Combinational result is available in the same cycle.
- A registered copy of the result is also provided, for downstream logic that needs a flopped value.
- Sits in the datapath as a leaf arithmetic block with a standalone self-checking bench.

Parameters:
- None. Width is fixed at 16 bits, built as 4 slices of 4 bits.

Ports:
- clk  input  1  system clock; all flops update on the rising edge
- rst  input  1  synchronous, active-high reset
- A  input  16  operand A, unsigned
- B  input  16  operand B, unsigned
- SUM  output  16  combinational sum, equal to (A+B)[15:0]
- CO  output  1  combinational carry-out, equal to (A+B)[16]
- SUM_Q  output  16  SUM registered on the rising edge of clk
- CO_Q  output  1  CO registered on the rising edge of clk
- OFL  output  1  signed overflow flag; present only with ADDER16_OFL_EN

Behaviour:
- Interface (already decided): one clock, clk. Reset is rst: synchronous and active-high.
- Full-adder cell:
  - s = a ^ b ^ ci
  - co = (a & b) | (ci & (a ^ b))
- Ripple chain:
  - Bit 0 carry-in is constant 0; there is no carry-in port.
  - The carry of bit i feeds bit i+1.
  - Each 4-bit slice passes its carry-out to the next slice.
  - Slice 3's carry-out is CO.
- SUM and CO are purely combinational, with zero-cycle latency.
  - No dependence on clk or rst.
  - SUM and CO must be valid during reset.
  - They must settle within the same clock period that A and B change.
- Arithmetic:
  - {CO, SUM} equals the 17-bit unsigned sum A+B for every input pair.
  - Wrap-around: SUM is modulo 2^16; CO=1 exactly when A+B >= 65536.
- Boundary values:
  - FFFF+FFFF gives SUM=FFFE, CO=1.
  - 0+0 gives SUM=0000, CO=0.
- No X propagation from the registered path into SUM or CO.
  - With A and B known, SUM and CO must be known (no X/Z), since the bench compares with !==.
- Registered path, on the rising edge of clk:
  - If rst=1: SUM_Q <= 16'h0000, CO_Q <= 0.
  - Otherwise: SUM_Q <= SUM, CO_Q <= CO.
  - Latency is exactly 1 cycle.
- Reset values: SUM_Q = 0 and CO_Q = 0. SUM, CO and OFL have no reset value (combinational).
- Reset asserted mid-stream:
  - SUM_Q and CO_Q clear on the first rising edge with rst=1 and stay 0 while rst is held.
  - The first edge after rst deasserts captures the current SUM/CO.
- No handshake. Inputs are sampled continuously.

Optional Feature:
- Macro ADDER16_OFL_EN.
- When defined:
  - Output port OFL is added.
  - OFL = (A[15] == B[15]) && (SUM[15] != A[15]), i.e. two's-complement overflow.
  - OFL is combinational and unregistered.
- When undefined:
  - The OFL port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Zero and reset: rst=1 for 2 cycles, A=0000, B=0000.
  - Required: SUM=0000, CO=0; SUM_Q=0000, CO_Q=0 after the first edge.
  - With ADDER16_OFL_EN: OFL=0.
- Full carry ripple: A=FFFF, B=0001.
  - Required: SUM=0000, CO=1 combinationally, with carry propagating through all 16 bits.
  - Required: SUM_Q=0000, CO_Q=1 one edge later.
- Max operands: A=FFFF, B=FFFF → SUM=FFFE, CO=1. Then A=8000, B=8000 → SUM=0000, CO=1, OFL=1.
- Signed overflow without carry: A=7FFF, B=0001 → SUM=8000, CO=0, OFL=1. A=1234, B=4321 → SUM=5555, CO=0, OFL=0.
- Random regression:
  - 400 random A/B pairs, applied on the rising edge and checked on the falling edge.
  - Required: SUM === (A+B)[15:0] and CO === (A+B)[16] every cycle.
  - Required: SUM_Q and CO_Q equal the previous cycle's values.
- Reset mid-operation: with nonzero traffic, assert rst for 1 cycle.
  - Required: SUM_Q and CO_Q are 0 on that edge, while SUM and CO still track A+B.
  - Required: the next edge after deassert captures the current sum.

Source files
------------

// File: rtl/ripple_adder16.sv
// ripple_adder16: 16-bit unsigned ripple-carry adder.
// The chain is four 4-bit slices of 1-bit full adders. Carry-in to bit 0 is tied to 0.
// SUM/CO are combinational. SUM_Q/CO_Q are the same result flopped once on clk,
// cleared by a synchronous active-high rst.
// Optional macro ADDER16_OFL_EN adds the combinational two's-complement overflow flag OFL.

`default_nettype none

module ripple_adder16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] SUM,
    output logic        CO,
    output logic [15:0] SUM_Q,
    output logic        CO_Q
`ifdef ADDER16_OFL_EN
    ,
    output logic        OFL
`endif
);

    localparam int unsigned SliceW    = 4;
    localparam int unsigned NumSlices = 4;

    // One full-adder cell; returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        logic s;
        logic co;
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
        return {co, s};
    endfunction

    logic [15:0]        sum_c;
    logic               co_c;
    logic [NumSlices:0] slice_carry;
    logic [15:0]        sum_q;
    logic               co_q;

    // Ripple the carry bit by bit; each slice hands its carry-out to the next slice.
    always_comb begin
        sum_c          = '0;
        slice_carry    = '0;
        slice_carry[0] = 1'b0;
        for (int s = 0; s < NumSlices; s++) begin
            logic carry;
            carry = slice_carry[s];
            for (int i = 0; i < SliceW; i++) begin
                logic [1:0] fa;
                fa                  = full_add(A[s*SliceW+i], B[s*SliceW+i], carry);
                sum_c[s*SliceW+i]   = fa[0];
                carry               = fa[1];
            end
            slice_carry[s+1] = carry;
        end
        co_c = slice_carry[NumSlices];
    end

    assign SUM = sum_c;
    assign CO  = co_c;

    // Registered copy of the result. It clears while rst is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 16'h0000;
            co_q  <= 1'b0;
        end else begin
            sum_q <= sum_c;
            co_q  <= co_c;
        end
    end

    assign SUM_Q = sum_q;
    assign CO_Q  = co_q;

`ifdef ADDER16_OFL_EN
    // Overflow occurs when the operands have the same sign and the sum has the other sign.
    assign OFL = (A[15] == B[15]) && (sum_c[15] != A[15]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_ripple_adder16.sv
// Self-checking bench for ripple_adder16.
// The queue holds the value the flop should hold after the next rising edge.

`timescale 1ns/1ps

module tb_ripple_adder16;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        co;
    logic [15:0] sum_q;
    logic        co_q;
`ifdef ADDER16_OFL_EN
    logic        ofl;
`endif

    int n_vec;
    int n_checks;
    int n_miscompares;

    logic [16:0] exp_q[$];

    ripple_adder16 dut (
        .clk   (clk),
        .rst   (rst),
        .A     (a),
        .B     (b),
        .SUM   (sum),
        .CO    (co),
        .SUM_Q (sum_q),
        .CO_Q  (co_q)
`ifdef ADDER16_OFL_EN
        ,
        .OFL   (ofl)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h (vector %0d)", tag, got, exp, n_vec);
        end
    endtask

    // Drive one vector just after a rising edge. At the falling edge, check the flop
    // against the previous vector's expected value and check the combinational outputs.
    task automatic apply(input logic [15:0] av, input logic [15:0] bv, input logic rv);
        logic [16:0] full;
        logic [16:0] prev;
        @(posedge clk);
        #1;
        a   = av;
        b   = bv;
        rst = rv;
        n_vec++;
        full = {1'b0, av} + {1'b0, bv};
        @(negedge clk);
        if (exp_q.size() > 0) begin
            prev = exp_q.pop_front();
            check("sum_q", {16'h0, sum_q}, {16'h0, prev[15:0]});
            check("co_q", {31'h0, co_q}, {31'h0, prev[16]});
        end
        check("sum", {16'h0, sum}, {16'h0, full[15:0]});
        check("co", {31'h0, co}, {31'h0, full[16]});
`ifdef ADDER16_OFL_EN
        check("ofl", {31'h0, ofl}, {31'h0, (av[15] == bv[15]) && (full[15] != av[15])});
`endif
        exp_q.push_back(rv ? 17'h0 : full);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        n_vec         = 0;
        n_checks      = 0;
        n_miscompares = 0;
        rst = 1'b1;
        a   = 16'h0;
        b   = 16'h0;

        // Hold reset for two cycles with zero operands.
        apply(16'h0000, 16'h0000, 1'b1);
        apply(16'h0000, 16'h0000, 1'b1);

        // Directed corner cases.
        apply(16'hFFFF, 16'h0001, 1'b0);
        check("dir_ripple_sum", {16'h0, sum}, 32'h0000_0000);
        check("dir_ripple_co", {31'h0, co}, 32'h1);
        apply(16'hFFFF, 16'hFFFF, 1'b0);
        check("dir_max_sum", {16'h0, sum}, 32'h0000_FFFE);
        apply(16'h8000, 16'h8000, 1'b0);
        apply(16'h7FFF, 16'h0001, 1'b0);
        check("dir_7fff_sum", {16'h0, sum}, 32'h0000_8000);
        apply(16'h1234, 16'h4321, 1'b0);
        check("dir_5555_sum", {16'h0, sum}, 32'h0000_5555);

        // Random regression.
        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            apply(ra, rb, 1'b0);
        end

        // Assert reset for one cycle during traffic, then resume.
        apply(16'hA5A5, 16'h7777, 1'b0);
        apply(16'hC3C3, 16'h4F4F, 1'b1);
        apply(16'h0F0F, 16'hF0F1, 1'b0);
        apply(16'h1111, 16'h2222, 1'b0);
        apply(16'h0000, 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompares);
        $finish;
    end

endmodule
